// File: rtl/input_stream_buffer_pkg.sv
// Shared sample format and read-side FSM encoding for the input stream buffer.
package input_stream_buffer_pkg;

  // Fixed-point sample format shared with the neuron layer
  localparam int INTEGER_WIDTH  = 4;
  localparam int FRACTION_WIDTH = 4;
  localparam int SAMPLE_W       = INTEGER_WIDTH + FRACTION_WIDTH;

  typedef logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] fixed_t;

  // Read-side FSM encoding
  typedef logic [1:0] rd_state_t;
  localparam rd_state_t RD_IDLE    = 2'd0;
  localparam rd_state_t RD_PRESENT = 2'd1;
  localparam rd_state_t RD_BUSY    = 2'd2;

endpackage

// File: rtl/input_stream_buffer_bank.sv
// One frame bank: NUM_INPUTS sample registers, single indexed write port, sync clear.
module input_bank
  import input_stream_buffer_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = 16,
  localparam int unsigned IDX_W = $clog2(NUM_INPUTS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_idx,
  input  fixed_t           i_data,
  output fixed_t           o_data [NUM_INPUTS]
);

  fixed_t r_mem [NUM_INPUTS];

  // Sample storage: cleared on reset, one slot written per accepted sample
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_INPUTS; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (i_we && (i_idx == IDX_W'(i))) r_mem[i] <= i_data;
      end
    end
  end

  assign o_data = r_mem;

endmodule

// File: rtl/input_stream_buffer.sv
// Ping-pong frame collector: serial samples in, NUM_INPUTS-wide frame out with a one-cycle inputs_ready pulse.
module input_stream_buffer
  import input_stream_buffer_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = 16
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   in_valid,
  input  fixed_t in_data,
  input  logic   in_last,
  output logic   in_ready,
  output fixed_t out_data [NUM_INPUTS],
  output logic   inputs_ready,
  input  logic   layer_done,
  output logic   frame_error
);

  localparam int unsigned IDX_W = $clog2(NUM_INPUTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);

  logic [1:0]       r_full;
  logic             r_wr_bank;
  logic             r_rd_bank;
  logic [IDX_W-1:0] r_wr_index;
  rd_state_t        r_rd_state;
  rd_state_t        w_rd_state_nxt;
  logic             r_inputs_ready;
  logic             r_frame_error;

  logic             w_accept;
  logic             w_at_last;
  logic             w_frame_done;
  logic             w_short_frame;
  logic             w_release;
  logic [1:0]       w_bank_we;
  logic [1:0]       w_full_set;
  logic [1:0]       w_full_clr;
  fixed_t           w_bank0_data [NUM_INPUTS];
  fixed_t           w_bank1_data [NUM_INPUTS];

  // Write-side decode; the write bank is never full while accepting
  assign in_ready      = !r_full[r_wr_bank];
  assign w_accept      = in_valid && in_ready;
  assign w_at_last     = (r_wr_index == LAST_IDX);
  assign w_frame_done  = w_accept && w_at_last;
  assign w_short_frame = w_accept && in_last && !w_at_last;
  assign w_release     = (r_rd_state == RD_BUSY) && layer_done;

  assign w_bank_we  = {w_accept && r_wr_bank, w_accept && !r_wr_bank};
  assign w_full_set = {w_frame_done && r_wr_bank, w_frame_done && !r_wr_bank};
  assign w_full_clr = {w_release && r_rd_bank, w_release && !r_rd_bank};

  input_bank #(.NUM_INPUTS(NUM_INPUTS)) u_bank0 (
    .clock  (clock),
    .reset  (reset),
    .i_we   (w_bank_we[0]),
    .i_idx  (r_wr_index),
    .i_data (in_data),
    .o_data (w_bank0_data)
  );

  input_bank #(.NUM_INPUTS(NUM_INPUTS)) u_bank1 (
    .clock  (clock),
    .reset  (reset),
    .i_we   (w_bank_we[1]),
    .i_idx  (r_wr_index),
    .i_data (in_data),
    .o_data (w_bank1_data)
  );

  // Write pointer and framing-error pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_index    <= '0;
      r_wr_bank     <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_frame_error <= (w_frame_done && !in_last) || w_short_frame;
      if (w_frame_done) begin
        r_wr_index <= '0;
        r_wr_bank  <= ~r_wr_bank;
      end else if (w_short_frame) begin
        r_wr_index <= '0;
      end else if (w_accept) begin
        r_wr_index <= r_wr_index + IDX_W'(1);
      end
    end
  end

  // Bank full flags; set and clear always address different banks
  always_ff @(posedge clock) begin
    if (reset) begin
      r_full    <= 2'b00;
      r_rd_bank <= 1'b0;
    end else begin
      r_full <= (r_full | w_full_set) & ~w_full_clr;
      if (w_release) r_rd_bank <= ~r_rd_bank;
    end
  end

  // Read FSM state register plus registered inputs_ready
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_state     <= RD_IDLE;
      r_inputs_ready <= 1'b0;
    end else begin
      r_rd_state     <= w_rd_state_nxt;
      r_inputs_ready <= (w_rd_state_nxt == RD_PRESENT);
    end
  end

  // Read FSM next state: announce a full bank once, then wait for the layer
  always_comb begin
    w_rd_state_nxt = r_rd_state;
    case (r_rd_state)
      RD_IDLE:    if (r_full[r_rd_bank]) w_rd_state_nxt = RD_PRESENT;
      RD_PRESENT: w_rd_state_nxt = RD_BUSY;
      RD_BUSY:    if (layer_done) w_rd_state_nxt = RD_IDLE;
      default:    w_rd_state_nxt = RD_IDLE;
    endcase
  end

  // Present the read bank to the layer
  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      out_data[i] = r_rd_bank ? w_bank1_data[i] : w_bank0_data[i];
    end
  end

  assign inputs_ready = r_inputs_ready;
  assign frame_error  = r_frame_error;

endmodule

// File: tb/tb_input_stream_buffer.sv
// Randomised and directed bench for input_stream_buffer against a frame-queue reference model.
module tb_input_stream_buffer;
  import input_stream_buffer_pkg::*;

  localparam int unsigned N = 4;

  typedef fixed_t frame_t [N];

  logic   clock = 1'b0;
  logic   reset = 1'b1;
  logic   in_valid = 1'b0;
  fixed_t in_data = '0;
  logic   in_last = 1'b0;
  logic   in_ready;
  fixed_t out_data [N];
  logic   inputs_ready;
  logic   layer_done = 1'b0;
  logic   frame_error;

  input_stream_buffer #(.NUM_INPUTS(N)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .inputs_ready (inputs_ready),
    .layer_done   (layer_done),
    .frame_error  (frame_error)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: completed frames held by the buffer, oldest first
  frame_t q_frames [$];
  int     q_cmpl   [$];
  frame_t part;
  int     part_cnt;
  int     head_present;
  int     free_at;
  bit     exp_err;
  bit     exp_zero;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_reset();
    q_frames.delete();
    q_cmpl.delete();
    part_cnt     = 0;
    head_present = -1;
    free_at      = 0;
    exp_err      = 1'b0;
    exp_zero     = 1'b1;
  endtask

  // One clock cycle: check outputs, drive inputs, advance the model
  task automatic step(input logic v, input fixed_t d, input logic l, input logic done,
                      input logic rst, output bit accepted);
    bit rdy;
    @(negedge clock);
    cyc++;
    rdy = (q_frames.size() < 2);
    check("in_ready", 32'(in_ready), 32'(rdy));
    check("inputs_ready", 32'(inputs_ready), 32'(cyc == head_present));
    check("frame_error", 32'(frame_error), 32'(exp_err));
    if (q_frames.size() > 0) begin
      for (int i = 0; i < N; i++)
        check("out_data", 32'($unsigned(out_data[i])), 32'($unsigned(q_frames[0][i])));
    end else if (exp_zero) begin
      for (int i = 0; i < N; i++)
        check("out_zero", 32'($unsigned(out_data[i])), 32'd0);
    end

    in_valid   = v;
    in_data    = d;
    in_last    = l;
    layer_done = done;
    reset      = rst;

    accepted = 1'b0;
    if (rst) begin
      model_reset();
    end else begin
      exp_zero = 1'b0;
      exp_err  = 1'b0;
      if (done && head_present >= 0 && cyc > head_present) begin
        void'(q_frames.pop_front());
        void'(q_cmpl.pop_front());
        free_at      = cyc + 2;
        head_present = (q_frames.size() > 0) ? imax(q_cmpl[0] + 2, cyc + 2) : -1;
      end
      if (v && rdy) begin
        accepted = 1'b1;
        part[part_cnt] = d;
        if (part_cnt == N - 1) begin
          q_frames.push_back(part);
          q_cmpl.push_back(cyc);
          exp_err  = !l;
          part_cnt = 0;
          if (q_frames.size() == 1) head_present = imax(cyc + 2, free_at);
        end else if (l) begin
          exp_err  = 1'b1;
          part_cnt = 0;
        end else begin
          part_cnt++;
        end
      end
    end
  endtask

  task automatic send(input fixed_t d, input logic l, input logic done);
    bit acc;
    acc = 1'b0;
    for (int k = 0; k < 40 && !acc; k++) step(1'b1, d, l, done, 1'b0, acc);
    if (!acc) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n, input logic done);
    bit acc;
    for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, done, 1'b0, acc);
  endtask

  task automatic send_frame(input fixed_t base, input logic with_last);
    for (int k = 0; k < N; k++)
      send(fixed_t'(base + fixed_t'(k)), with_last && (k == N - 1), 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    model_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    reset = 1'b0;

    // Single frame of known values, held until the layer finishes
    idle(1, 1'b0);
    send(8'sh10, 1'b0, 1'b0);
    send(8'sh28, 1'b0, 1'b0);
    send(fixed_t'(8'hF0), 1'b0, 1'b0);
    send(8'sh04, 1'b1, 1'b0);
    idle(4, 1'b0);
    check("t1_d0", 32'($unsigned(out_data[0])), 32'h10);
    check("t1_d1", 32'($unsigned(out_data[1])), 32'h28);
    check("t1_d2", 32'($unsigned(out_data[2])), 32'hF0);
    check("t1_d3", 32'($unsigned(out_data[3])), 32'h04);
    idle(3, 1'b0);
    idle(1, 1'b1);
    idle(3, 1'b0);

    // Two frames fill both banks, third stalls until a release
    send_frame(8'sh20, 1'b1);
    send_frame(8'sh30, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 8'sh40, 1'b0, 1'b0, 1'b0, acc);
      check("stall", 32'(acc), 32'd0);
    end
    idle(1, 1'b1);
    idle(1, 1'b0);
    send_frame(8'sh40, 1'b1);
    idle(4, 1'b0);
    idle(1, 1'b1);
    idle(4, 1'b0);
    idle(1, 1'b1);
    idle(4, 1'b0);

    // Early in_last discards the partial frame
    send(8'sh11, 1'b0, 1'b0);
    send(8'sh12, 1'b1, 1'b0);
    idle(3, 1'b0);
    send_frame(8'sh50, 1'b1);
    idle(4, 1'b0);
    idle(1, 1'b1);

    // Full frame without in_last is still presented
    send_frame(8'sh60, 1'b0);
    idle(4, 1'b0);
    idle(1, 1'b1);
    idle(3, 1'b0);

    // Reset while busy with both banks full
    send_frame(8'sh70, 1'b1);
    send_frame(fixed_t'(8'h80), 1'b1);
    idle(3, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, acc);
    idle(4, 1'b0);
    send_frame(fixed_t'(8'h90), 1'b1);
    idle(4, 1'b0);
    idle(1, 1'b1);
    idle(2, 1'b0);

    // Randomised traffic
    for (int k = 0; k < 1500; k++) begin
      logic   v, l, dn, rs;
      fixed_t d;
      v  = ($urandom_range(0, 9) < 7);
      d  = fixed_t'($urandom_range(0, 255));
      l  = (part_cnt == N - 1) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 29) == 0);
      dn = ($urandom_range(0, 4) == 0);
      rs = ($urandom_range(0, 199) == 0);
      step(v, d, l, dn, rs, acc);
    end
    idle(3, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
